// File: rtl/raster_tracker.sv
// Raster position tracker: registers a pixel stream and tags each output pixel
// with its column/row, line/frame boundary flags, border flag and frame count.
module raster_tracker #(
  parameter int WIDTH_P       = 8,
  parameter int COLS_P        = 640,
  parameter int ROWS_P        = 480,
  parameter int CNT_WIDTH_P   = 16,
  parameter int FRAME_WIDTH_P = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [WIDTH_P-1:0]       data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WIDTH_P-1:0]       data_o,
  output logic [CNT_WIDTH_P-1:0]   x_o,
  output logic [CNT_WIDTH_P-1:0]   y_o,
  output logic                     sol_o,
  output logic                     eol_o,
  output logic                     sof_o,
  output logic                     eof_o,
  output logic                     border_o,
  output logic [FRAME_WIDTH_P-1:0] frame_cnt_o,
  output logic                     busy_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [CNT_WIDTH_P-1:0] COL_LAST = CNT_WIDTH_P'(COLS_P - 1);
  localparam logic [CNT_WIDTH_P-1:0] ROW_LAST = CNT_WIDTH_P'(ROWS_P - 1);

  logic [0:0]               state_q, state_d;
  logic [CNT_WIDTH_P-1:0]   col_q, col_d;
  logic [CNT_WIDTH_P-1:0]   row_q, row_d;
  logic                     valid_q, valid_d;
  logic [WIDTH_P-1:0]       data_q, data_d;
  logic [CNT_WIDTH_P-1:0]   x_q, x_d;
  logic [CNT_WIDTH_P-1:0]   y_q, y_d;
  logic                     sol_q, sol_d;
  logic                     eol_q, eol_d;
  logic                     sof_q, sof_d;
  logic                     eof_q, eof_d;
  logic                     border_q, border_d;
  logic [FRAME_WIDTH_P-1:0] frame_q, frame_d;

  logic accept;
  logic col_last, row_last, col_first, row_first, pix_eof;

  // Ready depends only on clear and output-register occupancy, never on valid_i.
  assign ready_o   = ~clear_i & (~valid_q | ready_i);
  assign accept    = valid_i & ready_o;

  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign col_first = (col_q == '0);
  assign row_first = (row_q == '0);
  assign pix_eof   = col_last & row_last;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    valid_d  = valid_q;
    data_d   = data_q;
    x_d      = x_q;
    y_d      = y_q;
    sol_d    = sol_q;
    eol_d    = eol_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    border_d = border_q;
    frame_d  = frame_q;

    if (clear_i) begin
      col_d   = '0;
      row_d   = '0;
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (accept) begin
      // Flags describe the pixel being accepted, i.e. the pre-increment position.
      valid_d  = 1'b1;
      data_d   = data_i;
      x_d      = col_q;
      y_d      = row_q;
      sol_d    = col_first;
      eol_d    = col_last;
      sof_d    = col_first & row_first;
      eof_d    = pix_eof;
      border_d = col_first | col_last | row_first | row_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + CNT_WIDTH_P'(1);
      end else begin
        col_d = col_q + CNT_WIDTH_P'(1);
      end
      if (pix_eof) begin
        frame_d = frame_q + FRAME_WIDTH_P'(1);
        state_d = ST_IDLE;
      end else begin
        state_d = ST_ACTIVE;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      sol_q    <= 1'b0;
      eol_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      border_q <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sol_q    <= sol_d;
      eol_q    <= eol_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      border_q <= border_d;
      frame_q  <= frame_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign sol_o       = sol_q;
  assign eol_o       = eol_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign border_o    = border_q;
  assign frame_cnt_o = frame_q;
  assign busy_o      = (state_q == ST_ACTIVE);

endmodule
